// File: rtl/sub_top_nios2_qsys_0_cpu_debug_scan_master.sv
// sub_top_nios2_qsys_0_cpu_debug_scan_master
//
// Host-side initiator for the Nios II debug slave's virtual-JTAG port.
// It takes one command (IR value plus DR payload) and produces the strobe
// sequence UIR (only when the IR changes) -> CDR -> SDR x DR_WIDTH -> UDR.
// The DR contents shifted out of the slave come back as a response.
//
// Ports
//   clk, reset               system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_ir, cmd_data         IR value and DR payload (DR shifted LSB first)
//   rsp_valid                one-clk pulse when a scan completes
//   rsp_data, rsp_ir_out     captured DR contents, ir_out sampled during CDR
//   vji_tck, vji_tdi         generated scan clock and serial data out
//   vji_tdo, vji_ir_out      serial data and status from the slave
//   vji_ir_in                virtual IR value, held between UIR periods
//   vji_rti                  run-test-idle, high only while idle
//   vji_uir/cdr/sdr/udr      one-hot scan phase strobes
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | rti=1, tck parked low, waiting for a command
// UIR   | one tck period, ir_in loaded, update-IR strobe high
// CDR   | one tck period, slave captures, ir_out sampled on tck rise
// SDR   | DR_WIDTH tck periods, tdi driven at fall, tdo captured at rise
// UDR   | one tck period, update-DR strobe high, then back to IDLE

module sub_top_nios2_qsys_0_cpu_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);

    localparam int DIV_W = $clog2(2 * TCK_DIV + 1);
    localparam int SH_W  = $clog2(DR_WIDTH + 1);

    // The divider counts down across one tck period: tck is low while the
    // count is in the upper half and high in the lower half.
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [DIV_W-1:0] TCK_HALF = DIV_W'(TCK_DIV);
    localparam logic [DIV_W-1:0] RISE_PT  = DIV_W'(TCK_DIV - 1);
    localparam logic [SH_W-1:0]  SH_LOAD  = SH_W'(DR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [SH_W-1:0]     sh_q;
    logic [DR_WIDTH-1:0] data_q;
    logic [DR_WIDTH-1:0] cap_q;
    logic                ir_known_q;

    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DR_WIDTH-1:0] rsp_data_q;
    logic [IR_WIDTH-1:0] rsp_ir_out_q;
    logic                tck_q;
    logic                tdi_q;
    logic [IR_WIDTH-1:0] ir_in_q;
    logic                rti_q;
    logic                uir_q;
    logic                cdr_q;
    logic                sdr_q;
    logic                udr_q;

    logic accept;
    logic rise_d;
    logic start_d;

    always_comb begin
        accept  = cmd_valid & cmd_ready_q;
        state_d = state_q;
        div_d   = div_q;
        if (state_q == S_IDLE) begin
            if (accept) begin
                state_d = (!ir_known_q || (cmd_ir != ir_in_q)) ? S_UIR : S_CDR;
                div_d   = DIV_LOAD;
            end
        end else if (div_q == '0) begin
            div_d = DIV_LOAD;
            case (state_q)
                S_UIR:   state_d = S_CDR;
                S_CDR:   state_d = S_SDR;
                S_SDR:   state_d = (sh_q == '0) ? S_UDR : S_SDR;
                S_UDR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end else begin
            div_d = div_q - DIV_W'(1);
        end
        // rise/start describe the tck phase that the next cycle will show
        rise_d  = (state_d != S_IDLE) && (div_d == RISE_PT);
        start_d = (state_d != S_IDLE) && (div_d == DIV_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            sh_q         <= '0;
            data_q       <= '0;
            cap_q        <= '0;
            ir_known_q   <= 1'b0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_ir_out_q <= '0;
            tck_q        <= 1'b0;
            tdi_q        <= 1'b0;
            ir_in_q      <= '0;
            rti_q        <= 1'b1;
            uir_q        <= 1'b0;
            cdr_q        <= 1'b0;
            sdr_q        <= 1'b0;
            udr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cmd_ready_q <= (state_d == S_IDLE);
            tck_q       <= (state_d != S_IDLE) && (div_d < TCK_HALF);
            rti_q       <= (state_d == S_IDLE);
            uir_q       <= (state_d == S_UIR);
            cdr_q       <= (state_d == S_CDR);
            sdr_q       <= (state_d == S_SDR);
            udr_q       <= (state_d == S_UDR);

            if (accept && (state_d == S_UIR)) begin
                ir_in_q    <= cmd_ir;
                ir_known_q <= 1'b1;
            end

            // data_q doubles as the tdi shifter: bit 0 is always the next bit
            if (accept) begin
                data_q <= cmd_data;
            end else if ((state_d == S_SDR) && rise_d) begin
                data_q <= data_q >> 1;
            end

            case (state_d)
                S_CDR:   tdi_q <= (state_q == S_IDLE) ? cmd_data[0] : data_q[0];
                S_SDR:   if (start_d) tdi_q <= data_q[0];
                default: tdi_q <= 1'b0;
            endcase

            if ((state_d == S_SDR) && (state_q != S_SDR)) begin
                sh_q <= SH_LOAD;
            end else if ((state_d == S_SDR) && rise_d) begin
                sh_q  <= sh_q - SH_W'(1);
                cap_q <= {vji_tdo, cap_q[DR_WIDTH-1:1]};
            end

            if ((state_d == S_CDR) && rise_d) begin
                rsp_ir_out_q <= vji_ir_out;
            end

            rsp_valid_q <= (state_q == S_UDR) && (state_d == S_IDLE);
            if ((state_q == S_UDR) && (state_d == S_IDLE)) begin
                rsp_data_q <= cap_q;
            end
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_ir_out = rsp_ir_out_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_in_q;
    assign vji_rti    = rti_q;
    assign vji_uir    = uir_q;
    assign vji_cdr    = cdr_q;
    assign vji_sdr    = sdr_q;
    assign vji_udr    = udr_q;

endmodule

// File: tb/tb_sub_top_nios2_qsys_0_cpu_debug_scan_master.sv
module tb_sub_top_nios2_qsys_0_cpu_debug_scan_master;

    localparam logic [37:0] CAPV = 38'h15_5555_5555;
    localparam logic [50:0] RST_VEC = {1'b1, 1'b0, 38'h0, 2'b00, 1'b0, 1'b0,
                                       2'b00, 1'b1, 4'b0000};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0]  cmd_ir = 2'b00;
    logic [37:0] cmd_data = '0;
    logic cap_en = 1'b1;

    // unit a: TCK_DIV=4, unit b: TCK_DIV=1
    logic cmd_valid_a = 1'b0, cmd_ready_a, rsp_valid_a;
    logic [37:0] rsp_data_a;
    logic [1:0]  rsp_ir_out_a, ir_in_a;
    logic tck_a, tdi_a, tdo_a, rti_a, uir_a, cdr_a, sdr_a, udr_a;
    logic cmd_valid_b = 1'b0, cmd_ready_b, rsp_valid_b;
    logic [37:0] rsp_data_b;
    logic [1:0]  rsp_ir_out_b, ir_in_b;
    logic tck_b, tdi_b, tdo_b, rti_b, uir_b, cdr_b, sdr_b, udr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_top_nios2_qsys_0_cpu_debug_scan_master #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(4)) u_dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid_a),
        .rsp_data(rsp_data_a), .rsp_ir_out(rsp_ir_out_a), .vji_tck(tck_a),
        .vji_tdi(tdi_a), .vji_tdo(tdo_a), .vji_ir_in(ir_in_a), .vji_ir_out(2'b01),
        .vji_rti(rti_a), .vji_uir(uir_a), .vji_cdr(cdr_a), .vji_sdr(sdr_a), .vji_udr(udr_a)
    );

    sub_top_nios2_qsys_0_cpu_debug_scan_master #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(1)) u_dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid_b),
        .rsp_data(rsp_data_b), .rsp_ir_out(rsp_ir_out_b), .vji_tck(tck_b),
        .vji_tdi(tdi_b), .vji_tdo(tdo_b), .vji_ir_in(ir_in_b), .vji_ir_out(2'b01),
        .vji_rti(rti_b), .vji_uir(uir_b), .vji_cdr(cdr_b), .vji_sdr(sdr_b), .vji_udr(udr_b)
    );

    // slave models: capture CAPV on cdr (when enabled), shift on tck rise in sdr
    logic [37:0] sr_a = '0, sr_b = '0, sr_udr_a = '0, sr_udr_b = '0;
    int sdr_rise_a = 0;
    assign tdo_a = sr_a[0];
    assign tdo_b = sr_b[0];

    always @(posedge tck_a) begin
        if (cdr_a && cap_en) sr_a <= CAPV;
        else if (sdr_a) sr_a <= {tdi_a, sr_a[37:1]};
        if (sdr_a) sdr_rise_a++;
    end
    always @(posedge tck_b) begin
        if (cdr_b && cap_en) sr_b <= CAPV;
        else if (sdr_b) sr_b <= {tdi_b, sr_b[37:1]};
    end
    always @(posedge udr_a) sr_udr_a = sr_a;
    always @(posedge udr_b) sr_udr_b = sr_b;

    int uir_rise_a = 0, uir_cyc_a = 0, uir_cyc_b = 0, viol_a = 0, viol_b = 0;
    logic uir_prev_a = 1'b0;
    logic [1:0] uir_ir_a = 2'b00;
    always @(negedge clk) begin
        if (uir_a && !uir_prev_a) uir_rise_a++;
        if (uir_a) begin
            uir_cyc_a++;
            uir_ir_a = ir_in_a;
        end
        uir_prev_a = uir_a;
        if (uir_b) uir_cyc_b++;
        if ((int'(uir_a) + int'(cdr_a) + int'(sdr_a) + int'(udr_a)) > 1 ||
            rti_a == (uir_a | cdr_a | sdr_a | udr_a) || cmd_ready_a != rti_a) viol_a++;
        if ((int'(uir_b) + int'(cdr_b) + int'(sdr_b) + int'(udr_b)) > 1 ||
            rti_b == (uir_b | cdr_b | sdr_b | udr_b) || cmd_ready_b != rti_b) viol_b++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rsp_v(input int u);
        return (u == 0) ? rsp_valid_a : rsp_valid_b;
    endfunction

    function automatic logic [50:0] outs_a();
        return {cmd_ready_a, rsp_valid_a, rsp_data_a, rsp_ir_out_a, tck_a, tdi_a,
                ir_in_a, rti_a, uir_a, cdr_a, sdr_a, udr_a};
    endfunction

    function automatic logic [37:0] hs_d(input int k);
        return {6'(k), 32'hA5A5_0000 ^ 32'(k)};
    endfunction

    // issue one command and return clk edges from accept to rsp_valid
    task automatic run_cmd(input int u, input logic [1:0] ir, input logic [37:0] d,
                           output int lat);
        @(negedge clk);
        cmd_ir = ir;
        cmd_data = d;
        if (u == 0) cmd_valid_a = 1'b1; else cmd_valid_b = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
        lat = 0;
        while (!rsp_v(u) && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat, n, tck_hi, base, rsp_seen, nrsp, ready_bad;
        int rsp_k[3];
        logic [37:0] rsp_d[3];

        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 64'(outs_a()), 64'(RST_VEC));
        @(negedge clk);
        reset = 1'b0;
        tck_hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (tck_a) tck_hi++;
        end
        chk("idle_ready", 64'(cmd_ready_a), 64'd1);
        chk("idle_tck", 64'(tck_hi), 64'd0);

        // first command: uir, capture, shift-in
        run_cmd(0, 2'b10, 38'h20_0000_0001, lat);
        chk("s1_latency", 64'(lat), 64'd328);
        chk("s1_rsp_data", 64'(rsp_data_a), 64'(CAPV));
        chk("s1_rsp_ir", 64'(rsp_ir_out_a), 64'd1);
        chk("s1_sr_udr", 64'(sr_udr_a), 64'h20_0000_0001);
        chk("s1_uir_pulses", 64'(uir_rise_a), 64'd1);
        chk("s1_uir_cycles", 64'(uir_cyc_a), 64'd8);
        chk("s1_uir_ir", 64'(uir_ir_a), 64'd2);
        @(posedge clk);
        #1;
        chk("s1_rsp_pulse", 64'(rsp_valid_a), 64'd0);

        // second command, same IR, slave loops back the previous payload
        cap_en = 1'b0;
        run_cmd(0, 2'b10, 38'h0A_BCDE_F012, lat);
        chk("s2_latency", 64'(lat), 64'd320);
        chk("s2_rsp_data", 64'(rsp_data_a), 64'h20_0000_0001);
        chk("s2_no_uir", 64'(uir_rise_a), 64'd1);
        chk("s2_sr_udr", 64'(sr_udr_a), 64'h0A_BCDE_F012);

        // handshake with cmd_valid held and data changing every cycle
        @(negedge clk);
        cmd_ir = 2'b10;
        cmd_data = hs_d(0);
        cmd_valid_a = 1'b1;
        nrsp = 0;
        ready_bad = 0;
        for (int k = 1; k <= 963; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid_a) begin
                if (nrsp < 3) begin
                    rsp_k[nrsp] = k;
                    rsp_d[nrsp] = rsp_data_a;
                end
                nrsp++;
            end
            if (cmd_ready_a && !rsp_valid_a) ready_bad++;
            if (k == 963) cmd_valid_a = 1'b0;
            else cmd_data = hs_d(k);
        end
        chk("hs_nrsp", 64'(nrsp), 64'd3);
        chk("hs_rsp0_at", 64'(rsp_k[0]), 64'd321);
        chk("hs_rsp1_at", 64'(rsp_k[1]), 64'd642);
        chk("hs_rsp2_at", 64'(rsp_k[2]), 64'd963);
        chk("hs_rsp0_data", 64'(rsp_d[0]), 64'h0A_BCDE_F012);
        chk("hs_rsp1_data", 64'(rsp_d[1]), 64'(hs_d(0)));
        chk("hs_rsp2_data", 64'(rsp_d[2]), 64'(hs_d(321)));
        chk("hs_ready_busy", 64'(ready_bad), 64'd0);
        repeat (5) @(negedge clk);
        chk("hs_no_accept", 64'(cmd_ready_a), 64'd1);

        // abort after the 10th SDR rising edge
        cap_en = 1'b1;
        base = sdr_rise_a;
        @(negedge clk);
        cmd_data = 38'h3F_0000_FFFF;
        cmd_valid_a = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_a = 1'b0;
        n = 0;
        while (sdr_rise_a < base + 10 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reached", 64'(n < 2000), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_outs", 64'(outs_a()), 64'(RST_VEC));
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rsp_seen = 0;
        repeat (400) begin
            @(negedge clk);
            if (rsp_valid_a) rsp_seen++;
        end
        chk("abort_no_rsp", 64'(rsp_seen), 64'd0);
        base = uir_rise_a;
        run_cmd(0, 2'b10, 38'h3F_0000_FFFF, lat);
        chk("abort_uir_again", 64'(uir_rise_a - base), 64'd1);
        chk("abort_latency", 64'(lat), 64'd328);
        chk("abort_rsp_data", 64'(rsp_data_a), 64'(CAPV));

        // TCK_DIV=1 instance
        base = uir_cyc_b;
        run_cmd(1, 2'b10, 38'h20_0000_0001, lat);
        chk("div1_latency", 64'(lat), 64'd82);
        chk("div1_uir_cycles", 64'(uir_cyc_b - base), 64'd2);
        chk("div1_rsp_data", 64'(rsp_data_b), 64'(CAPV));
        chk("div1_rsp_ir", 64'(rsp_ir_out_b), 64'd1);
        chk("div1_sr_udr", 64'(sr_udr_b), 64'h20_0000_0001);
        cap_en = 1'b0;
        run_cmd(1, 2'b10, 38'h0A_BCDE_F012, lat);
        chk("div1_s2_latency", 64'(lat), 64'd80);
        chk("div1_s2_rsp_data", 64'(rsp_data_b), 64'h20_0000_0001);

        repeat (3) @(negedge clk);
        chk("strobe_rules_a", 64'(viol_a), 64'd0);
        chk("strobe_rules_b", 64'(viol_b), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_top_nios2_qsys_0_cpu_debug_scan_master.md
Name: sub_top_nios2_qsys_0_cpu_debug_scan_master

Overview:
- Host-side initiator for the Nios II debug slave's virtual-JTAG interface.
- Turns a command (IR value plus DR payload) into the virtual-JTAG strobe sequence the debug slave consumes: tck, tdi, uir/cdr/sdr/udr, rti and ir_in.
- Samples tdo and ir_out and returns the captured DR contents as a response.
- Used for in-system debug injection from fabric logic and as the driver in debug-slave simulation benches, replacing the sld_virtual_jtag_basic phy.

Parameters:
- DR_WIDTH, 38, data-register scan length in bits; equals the debug slave sr width.
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 4, clk cycles per tck half-period; legal range 1 to 255.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_ir  in  IR_WIDTH  IR value for this scan.
- cmd_data  in  DR_WIDTH  DR value shifted in, LSB first.
- rsp_valid  out  1  one-clk pulse when a scan completes.
- rsp_data  out  DR_WIDTH  DR contents shifted out of the slave.
- rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during CDR.
- vji_tck  out  1  generated scan clock.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  virtual IR value.
- vji_ir_out  in  IR_WIDTH  slave status.
- vji_rti  out  1  run-test-idle.
- vji_uir  out  1  update-IR strobe.
- vji_cdr  out  1  capture-DR strobe.
- vji_sdr  out  1  shift-DR strobe.
- vji_udr  out  1  update-DR strobe.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_ir_out=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, vji_rti=1, all strobes 0, ir_known=0.
- Reset mid-scan: all outputs return to reset values immediately, the scan is aborted, and no rsp_valid is produced.
- States: IDLE, UIR, CDR, SDR, UDR.
- One tck period = 2*TCK_DIV clk cycles. tck is low for the first TCK_DIV cycles of each period and high for the second. A divider counter restarts at every state entry.
- IDLE: rti=1, tck held 0, cmd_ready=1. A command is accepted on a clk edge with cmd_valid&cmd_ready; cmd_ir and cmd_data are latched.
- Next state after accept:
  - UIR if ir_known=0 or cmd_ir differs from the current vji_ir_in.
  - Otherwise CDR.
- UIR, one tck period: vji_ir_in is loaded with the latched IR on entry and held until the next UIR or reset. vji_uir=1 for the whole period. ir_known is set. Next state is CDR.
- CDR, one tck period: vji_cdr=1. rsp_ir_out is sampled on the tck rising edge. tdi=bit0 of the latched data.
- SDR, DR_WIDTH tck periods: vji_sdr=1.
  - tdi changes only at tck falling points (period start) and presents data bit k in period k, so LSB goes first.
  - On each tck rising point, the capture register shifts {vji_tdo, cap[DR_WIDTH-1:1]}.
  - A shift counter (width clog2(DR_WIDTH+1)) ends the state after exactly DR_WIDTH rising edges.
- UDR, one tck period: vji_udr=1, tdi=0. Next state is IDLE.
- On the IDLE entry cycle: rsp_valid=1 for exactly one clk, and rsp_data<=cap. rsp_data holds until the next completion. A new command may be accepted in that same cycle.
- Latency, from the accept edge to rsp_valid: (DR_WIDTH+3)*2*TCK_DIV cycles with UIR, and (DR_WIDTH+2)*2*TCK_DIV without. Defaults give 328 and 320.
- At most one strobe among uir/cdr/sdr/udr is high at any time. rti is 0 outside IDLE.
- cmd_valid while busy is ignored and not queued. cmd inputs are sampled only at accept.

Test Plan:
- Reset: assert reset for 3 clk, check all outputs at their reset values. Deassert and check cmd_ready=1 and vji_tck stays 0 while idle.
- First command, with a bench model of the slave (38-bit sr, loads 38'h15_5555_5555 on cdr, shifts on tck rise while sdr, tdo=sr[0], ir_out=2'b01):
  - Stimulus: cmd_ir=2'b10, cmd_data=38'h20_0000_0001.
  - Required: exactly one uir period with ir_in=2'b10; rsp_data=38'h15_5555_5555; rsp_ir_out=2'b01; model sr=38'h20_0000_0001 at udr; rsp_valid exactly 328 clk after accept.
- Second command with the same IR (cmd_ir=2'b10): no uir pulse, rsp_valid at 320 clk, and rsp_data equals the previous cmd_data.
- Handshake: hold cmd_valid high continuously with changing cmd_data.
  - Only values present at IDLE cycles are accepted.
  - The next command is accepted in the same cycle as rsp_valid.
  - cmd_ready=0 throughout the scan.
- Abort: assert reset after the 10th SDR rising edge.
  - Outputs reach reset values without any clk edge; no rsp_valid follows.
  - The next command with cmd_ir=2'b10 performs uir again.
- TCK_DIV=1, DR_WIDTH=38: tck period is 2 clk, first-command latency is 82 clk, and the data result matches the second scenario.
